// File: rtl/tpu_pkg.sv
// Shared TPU definitions: MMU phase timing, accumulator width and result ordering.
package tpu_pkg;

  // Default accumulator width of the systolic MMU (8 or 16).
  localparam int ACC_W_DEFAULT = 16;

  // Cycle indices within an MMU feed/compute phase, shared with the control unit.
  localparam logic [2:0] MMU_CYC_C00     = 3'd2;
  localparam logic [2:0] MMU_CYC_C01_C10 = 3'd3;
  localparam logic [2:0] MMU_CYC_C11     = 3'd4;
  localparam logic [2:0] MMU_CYC_LAST    = 3'd5;

  // Order in which result elements leave the chip; also their slot in a packed set.
  typedef enum logic [1:0] {
    ELEM_C00 = 2'd0,
    ELEM_C01 = 2'd1,
    ELEM_C10 = 2'd2,
    ELEM_C11 = 2'd3
  } result_elem_e;

  // Output serializer states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/result_serializer_byte_shifter.sv
// Parallel-load shift buffer presenting one byte at a time, advanced by valid/ready.
module byte_shifter
  import tpu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [4*ACC_W-1:0] load_data,
  input  logic               valid,
  input  logic               ready,
  output logic [7:0]         data,
  output logic               last_accept
);

  localparam int BPE    = ACC_W / 8;
  localparam int NBYTES = 4 * BPE;
  localparam int CNT_W  = $clog2(NBYTES);

  logic [4*ACC_W-1:0] sbuf;
  logic [CNT_W-1:0]   byte_cnt;
  logic               is_last;
  logic               advance;

  assign advance     = valid && ready;
  assign is_last     = (byte_cnt == CNT_W'(NBYTES - 1));
  assign last_accept = advance && is_last;
  // The current byte always sits in the low byte; after the final accept the
  // buffer is left untouched so data keeps its last value while idle.
  assign data        = sbuf[7:0];

  // Load a fresh set, or drop the accepted byte and count it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data buffer is reset too, so a reset mid-stream can never leak old bytes.
      sbuf     <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      sbuf     <= load_data;
      byte_cnt <= '0;
    end else if (advance && !is_last) begin
      sbuf     <= sbuf >> 8;
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/result_serializer.sv
// Captures 2x2 MMU results during the compute phase into a double buffer and
// streams each completed set off-chip one byte per valid/ready handshake.
module result_serializer
  import tpu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmu_en,
  input  logic [2:0]       mmu_cycle,
  input  logic [ACC_W-1:0] c00,
  input  logic [ACC_W-1:0] c01,
  input  logic [ACC_W-1:0] c10,
  input  logic [ACC_W-1:0] c11,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             done,
  output logic             overrun,
  output logic             busy
);

  logic [ACC_W-1:0]          cap00, cap01, cap10;
  logic [3:0][ACC_W-1:0]     pend;
  logic                      pending;
  ser_state_e                state, next_state;
  logic                      cap_last;
  logic                      promote;
  logic                      last_accept;

  assign cap_last  = mmu_en && (mmu_cycle == MMU_CYC_C11);
  assign out_valid = (state == ST_STREAM);
  assign busy      = out_valid || pending;

  // Collect partial results as they appear; a complete set lands in pend at cycle 4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap00 <= '0;
      cap01 <= '0;
      cap10 <= '0;
      pend  <= '0;
    end else if (mmu_en) begin
      // NOTE: non-blocking assignments make pend see the cap registers' old values this edge.
      case (mmu_cycle)
        MMU_CYC_C00: cap00 <= c00;
        MMU_CYC_C01_C10: begin
          cap01 <= c01;
          cap10 <= c10;
        end
        MMU_CYC_C11: begin
          pend[ELEM_C00] <= cap00;
          pend[ELEM_C01] <= cap01;
          pend[ELEM_C10] <= cap10;
          pend[ELEM_C11] <= c11;
        end
        default: ;
      endcase
    end
  end

  // Pending flag, sticky overrun, registered done pulse and state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      overrun <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= next_state;
      if (cap_last) begin
        pending <= 1'b1;
      end else if (promote) begin
        pending <= 1'b0;
      end
      if (cap_last && pending && !promote) begin
        overrun <= 1'b1;
      end
      done <= last_accept;
    end
  end

  // Next-state logic: promote a pending set when idle, return to idle after the last byte.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    next_state = state;
    promote    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pending) begin
          promote    = 1'b1;
          next_state = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_accept) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  byte_shifter #(
    .ACC_W(ACC_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (promote),
    .load_data  (pend),
    .valid      (out_valid),
    .ready      (out_ready),
    .data       (out_data),
    .last_accept(last_accept)
  );

endmodule
